// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline register with a valid/ready handshake and a
// one-entry skid buffer. Full throughput, one cycle of latency, and a
// synchronous FLUSH that squashes everything held.
//
// Optional feature: define PIPE_SKID_STALL_CNT_EN to add the STALL_CNT
// port, a saturating count of edges where upstream was held off.
//
// Handshake: a payload moves across an interface on a rising CLK edge
// exactly when valid and ready are both 1 at that edge. A producer
// holding valid=1 keeps its payload stable until it is accepted. Here
// IN_READY comes only from flops, so there is no combinational path
// from OUT_READY or IN_VALID to IN_READY.
module pipe_skid_reg #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter int unsigned           STALL_CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         D,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         Q
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]   STALL_CNT
`endif
);

    // State is the {mv, sv} valid-flag pair. The value 01 is never reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   s_q;
    logic               m_load;
    logic               m_from_s;
    logic               s_load;
    logic               acc;
    logic               tk;

    assign IN_READY  = ~state[0];
    assign OUT_VALID = state[1];
    assign Q         = m_q;
    assign acc       = IN_VALID & IN_READY;
    assign tk        = OUT_VALID & OUT_READY;

    // State register: the pair of valid flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and data-load strobes; FLUSH empties without loading.
    always_comb begin
        state_nxt = state;
        m_load    = 1'b0;
        m_from_s  = 1'b0;
        s_load    = 1'b0;
        if (FLUSH) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        m_load    = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && tk) begin
                        m_load    = 1'b1;
                    end else if (acc) begin
                        state_nxt = TWO;
                        s_load    = 1'b1;
                    end else if (tk) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // IN_READY is low here, so only the take matters.
                    if (tk) begin
                        state_nxt = ONE;
                        m_load    = 1'b1;
                        m_from_s  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Payload registers: M feeds Q; S holds the younger payload under back-pressure.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_q <= RESET_VALUE;
            s_q <= RESET_VALUE;
        end else begin
            if (m_load) begin
                m_q <= m_from_s ? s_q : D;
            end
            if (s_load) begin
                s_q <= D;
            end
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturating count of edges where upstream offered data but was refused.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            STALL_CNT <= '0;
        end else if (IN_VALID && !IN_READY && (STALL_CNT != {STALL_CNT_W{1'b1}})) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline register with a valid/ready handshake and a one-entry skid buffer. It replaces the plain enable register between datapath stages (fetch/decode/execute) so that back-pressure can be applied without a combinational ready path. It provides full throughput, one cycle of latency and a synchronous flush for branch/exception squash.

Parameters:
WIDTH, 32, payload width in bits (>=1).
RESET_VALUE, 0, value loaded into Q and the skid register on reset (WIDTH bits).
STALL_CNT_W, 16, width of the optional stall counter (used only when PIPE_SKID_STALL_CNT_EN is defined).

Ports:
CLK  input  1  rising-edge clock.
RESET_N  input  1  asynchronous, active-low reset.
FLUSH  input  1  synchronous squash; drops all held data.
IN_VALID  input  1  upstream has a payload on D.
IN_READY  output  1  block can accept a payload this cycle.
D  input  WIDTH  upstream payload.
OUT_VALID  output  1  Q holds a valid payload.
OUT_READY  input  1  downstream takes Q this cycle.
Q  output  WIDTH  payload to downstream, driven directly from a flop.
STALL_CNT  output  STALL_CNT_W  present only with PIPE_SKID_STALL_CNT_EN.

Behaviour:
- Storage: main register M (drives Q) with valid flag mv; skid register S with valid flag sv.
- State is encoded by {mv,sv}: EMPTY=00, ONE=10, TWO=11. The value 01 is illegal and never reached.
- IN_READY = !sv. It is a pure function of flops, with no combinational path from OUT_READY or IN_VALID. OUT_VALID = mv.
- Accept (acc) = IN_VALID & IN_READY. Take (tk) = OUT_VALID & OUT_READY.
- Reset (RESET_N=0, asynchronous):
  - mv=0, sv=0.
  - M=S=RESET_VALUE.
  - Resulting outputs: OUT_VALID=0, IN_READY=1, Q=RESET_VALUE.
- Transitions on the rising CLK edge when FLUSH=0:
  - EMPTY: acc -> ONE, M<=D. No acc -> stay.
  - ONE: acc&tk -> ONE, M<=D. acc&!tk -> TWO, S<=D. !acc&tk -> EMPTY. Neither -> stay.
  - TWO (IN_READY=0, so acc is impossible): tk -> ONE, M<=S. No tk -> stay.
- FLUSH=1 has highest priority below reset:
  - Next state is EMPTY.
  - Any payload presented that cycle is discarded, even if IN_READY=1.
  - M and S data are not modified.
- Q while OUT_VALID=0 holds its last value. It is not required to be zero.
- Latency: a payload accepted at edge n is visible on Q after edge n.
- Throughput: one transfer per cycle when OUT_READY is held at 1.
- Ordering: strict FIFO. The S payload is always younger than the M payload.
- Held data: M and S never change while their valid flag is set unless the transition table above moves them.
- OUT_READY asserted while OUT_VALID=0 has no effect.
- Reset asserted mid-transfer: all payloads are lost and the outputs take their reset values immediately, without waiting for CLK.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Adds port STALL_CNT, reset to 0.
  - Increments by 1 on each edge where IN_VALID=1 and IN_READY=0.
  - Saturates at all-ones. Cleared by reset only; FLUSH does not clear it.
- Undefined: the port and the counter logic do not exist. Behaviour is otherwise identical.

Test Plan:
1. Reset: RESET_N=0 asynchronously mid-cycle with state TWO -> immediately OUT_VALID=0, IN_READY=1, Q=0x00000000.
2. Streaming: OUT_READY=1; present D=0x11,0x22,0x33 on consecutive cycles with IN_VALID=1 -> Q shows 0x11,0x22,0x33 on the following three cycles; IN_READY stays 1.
3. Back-pressure: send 0xA0 and 0xA1 with OUT_READY=0 -> state TWO, IN_READY=0, Q=0xA0. Then OUT_READY=1 for two cycles -> Q=0xA0 then 0xA1, then OUT_VALID=0; no data lost or duplicated.
4. Flush: in state TWO, assert FLUSH=1 together with IN_VALID=1, D=0xFF -> next cycle OUT_VALID=0, IN_READY=1; 0xFF never appears on Q.
5. Simultaneous accept and take in ONE: Q=0x5, present D=0x6 with OUT_READY=1 -> next Q=0x6, OUT_VALID=1, S unused (IN_READY stays 1).
6. With PIPE_SKID_STALL_CNT_EN and STALL_CNT_W=4: hold TWO with IN_VALID=1 for 20 cycles -> STALL_CNT=15 (saturated). FLUSH -> still 15. Reset -> 0.
